// File: rtl/dpram_be_wrseq_pkg.sv
// Shared definitions for the dpram_be port-A write sequencer:
// address-width helper, default geometry and FSM state encoding.
package dpram_be_wrseq_pkg;

   function automatic int log2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int DEF_MEMD  = 1024;
   localparam int DEF_DATAW = 90;
   localparam int DEF_BYTEW = 9;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      RESP
   } state_t;

endpackage

// File: rtl/dpram_be_wrseq_if.sv
// Request/response bus plus RAM port-A signals of the sequencer.
// slave = sequencer side, master = requester and RAM side.
interface dpram_be_wrseq_if
   import dpram_be_wrseq_pkg::*;
#(
   parameter int MEMD  = DEF_MEMD,
   parameter int DATAW = DEF_DATAW,
   parameter int BYTEW = DEF_BYTEW
)();
   localparam int nBYTE = DATAW / BYTEW;
   localparam int ADDRW = log2(MEMD);

   logic             reqValid;
   logic             reqReady;
   logic             reqWr;
   logic [ADDRW-1:0] reqAddr;
   logic [nBYTE-1:0] reqMask;
   logic [DATAW-1:0] reqData;
   logic             wrDone;
   logic             rspValid;
   logic [DATAW-1:0] rspData;
   logic             busy;
   logic             wEnbA;
   logic [nBYTE-1:0] bEnbA;
   logic [ADDRW-1:0] addrA;
   logic [BYTEW-1:0] wDataA;
   logic [DATAW-1:0] rDataA;

   modport master (
      output reqValid, reqWr, reqAddr, reqMask, reqData, rDataA,
      input  reqReady, wrDone, rspValid, rspData, busy,
      input  wEnbA, bEnbA, addrA, wDataA
   );

   modport slave (
      input  reqValid, reqWr, reqAddr, reqMask, reqData, rDataA,
      output reqReady, wrDone, rspValid, rspData, busy,
      output wEnbA, bEnbA, addrA, wDataA
   );

endinterface

// File: rtl/dpram_be_wrseq_pe_lsb_onehot.sv
// Lowest-set-bit priority encoder: one-hot select, binary index and any-flag.
module pe_lsb_onehot #(
   parameter  int WIDTH = 8,
   localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
)(
   input  logic [WIDTH-1:0] mask,
   output logic [WIDTH-1:0] oneHot,
   output logic [IDXW-1:0]  index,
   output logic             any
);

   always_comb begin
      oneHot = mask & (~mask + WIDTH'(1));
      any    = |mask;
      index  = '0;
      // Descending scan so the lowest set bit is the last one assigned.
      for (int unsigned i = WIDTH; i > 0; i--) begin
         if (mask[i-1]) index = IDXW'(i - 1);
      end
   end

endmodule

// File: rtl/dpram_be_wrseq.sv
// Port-A sequencer for dpram_be: serializes masked word writes into one-hot
// byte writes (ascending order, one per clock) and issues word reads.
module dpram_be_wrseq
   import dpram_be_wrseq_pkg::*;
#(
   parameter int MEMD  = DEF_MEMD,
   parameter int DATAW = DEF_DATAW,
   parameter int BYTEW = DEF_BYTEW
)(
   input  logic             clk,
   input  logic             rstn,
   dpram_be_wrseq_if.slave  bus
);
   localparam int nBYTE = DATAW / BYTEW;
   localparam int ADDRW = log2(MEMD);
   localparam int IDXW  = (nBYTE > 1) ? $clog2(nBYTE) : 1;

   state_t           state;
   logic [nBYTE-1:0] maskQ;
   logic [DATAW-1:0] dataQ;
   logic             wEnbQ;
   logic [nBYTE-1:0] bEnbQ;
   logic [ADDRW-1:0] addrQ;
   logic [BYTEW-1:0] wDataQ;
   logic             wrDoneQ;
   logic             rspValidQ;

   logic [nBYTE-1:0] peIn;
   logic [nBYTE-1:0] peOneHot;
   logic [nBYTE-1:0] restMask;
   logic [IDXW-1:0]  peIdx;
   logic             peAny;
   logic [DATAW-1:0] srcData;
   logic [BYTEW-1:0] byteLane [nBYTE];
   logic [BYTEW-1:0] byteSel;

   pe_lsb_onehot #(.WIDTH(nBYTE)) uPe (
      .mask   (peIn),
      .oneHot (peOneHot),
      .index  (peIdx),
      .any    (peAny)
   );

   // In IDLE the encoder looks at the incoming request so the first byte is
   // registered on the accepting edge; afterwards it walks the latched mask.
   always_comb begin
      peIn     = (state == IDLE) ? bus.reqMask : maskQ;
      srcData  = (state == IDLE) ? bus.reqData : dataQ;
      restMask = peIn & ~peOneHot;
      for (int unsigned i = 0; i < nBYTE; i++) begin
         byteLane[i] = srcData[i*BYTEW +: BYTEW];
      end
      byteSel = byteLane[peIdx];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         maskQ     <= '0;
         dataQ     <= '0;
         wEnbQ     <= 1'b0;
         bEnbQ     <= '0;
         addrQ     <= '0;
         wDataQ    <= '0;
         wrDoneQ   <= 1'b0;
         rspValidQ <= 1'b0;
      end else begin
         wrDoneQ   <= 1'b0;
         rspValidQ <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.reqValid) begin
                  if (bus.reqWr) begin
                     if (peAny) begin
                        addrQ   <= bus.reqAddr;
                        dataQ   <= bus.reqData;
                        maskQ   <= restMask;
                        wEnbQ   <= 1'b1;
                        bEnbQ   <= peOneHot;
                        wDataQ  <= byteSel;
                        wrDoneQ <= (restMask == '0);
                        state   <= WRITE;
                     end else begin
                        wrDoneQ <= 1'b1;
                     end
                  end else begin
                     addrQ <= bus.reqAddr;
                     state <= READ;
                  end
               end
            end
            WRITE: begin
               if (peAny) begin
                  maskQ   <= restMask;
                  bEnbQ   <= peOneHot;
                  wDataQ  <= byteSel;
                  wrDoneQ <= (restMask == '0);
               end else begin
                  wEnbQ <= 1'b0;
                  bEnbQ <= '0;
                  state <= IDLE;
               end
            end
            READ: begin
               rspValidQ <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.reqReady = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.wrDone   = wrDoneQ;
   assign bus.rspValid = rspValidQ;
   assign bus.rspData  = bus.rDataA;
   assign bus.wEnbA    = wEnbQ;
   assign bus.bEnbA    = bEnbQ;
   assign bus.addrA    = addrQ;
   assign bus.wDataA   = wDataQ;

endmodule

// File: tb/tb_dpram_be_wrseq.sv
// Directed bench for dpram_be_wrseq with a behavioural byte-enabled RAM on port A.
module tb_dpram_be_wrseq;
   localparam int MEMD  = 1024;
   localparam int DATAW = 90;
   localparam int BYTEW = 9;
   localparam int NB    = DATAW / BYTEW;
   localparam int AW    = 10;

   logic clk;
   logic rstn;
   int   nChecks;
   int   nErrors;
   int   wrDoneCnt;
   int   rspCnt;
   int   wenCnt;

   logic [DATAW-1:0] ram    [MEMD] = '{default: '0};
   logic [DATAW-1:0] refMem [MEMD] = '{default: '0};

   dpram_be_wrseq_if #(.MEMD(MEMD), .DATAW(DATAW), .BYTEW(BYTEW)) bus ();

   dpram_be_wrseq #(.MEMD(MEMD), .DATAW(DATAW), .BYTEW(BYTEW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.wEnbA) begin
         for (int j = 0; j < NB; j++) begin
            if (bus.bEnbA[j]) ram[bus.addrA][j*BYTEW +: BYTEW] <= bus.wDataA;
         end
      end
      bus.rDataA <= ram[bus.addrA];
   end

   always @(negedge clk) begin
      if (bus.wrDone)   wrDoneCnt++;
      if (bus.rspValid) rspCnt++;
      if (bus.wEnbA)    wenCnt++;
   end

   task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATAW-1:0] mkWord(input int base);
      logic [DATAW-1:0] w;
      for (int i = 0; i < NB; i++) w[i*BYTEW +: BYTEW] = BYTEW'(base + i);
      return w;
   endfunction

   function automatic logic [DATAW-1:0] merge(input logic [DATAW-1:0] old,
                                              input logic [DATAW-1:0] nw,
                                              input logic [NB-1:0] m);
      logic [DATAW-1:0] w;
      w = old;
      for (int i = 0; i < NB; i++) if (m[i]) w[i*BYTEW +: BYTEW] = nw[i*BYTEW +: BYTEW];
      return w;
   endfunction

   // Entered and left on a negedge with the DUT idle.
   task automatic doWrite(input string tag, input logic [AW-1:0] a,
                          input logic [NB-1:0] m, input logic [DATAW-1:0] d);
      int k;
      int n;
      logic [NB-1:0] oh;
      checkVal({tag, "_ready"}, bus.reqReady, 1);
      bus.reqValid = 1'b1; bus.reqWr = 1'b1; bus.reqAddr = a; bus.reqMask = m; bus.reqData = d;
      refMem[a] = merge(refMem[a], d, m);
      k = $countones(m);
      @(negedge clk);
      bus.reqValid = 1'b0;
      if (k == 0) begin
         checkVal({tag, "_z_wen"}, bus.wEnbA, 0);
         checkVal({tag, "_z_done"}, bus.wrDone, 1);
         checkVal({tag, "_z_ready"}, bus.reqReady, 1);
         @(negedge clk);
      end else begin
         n = 0;
         for (int j = 0; j < NB; j++) begin
            if (m[j]) begin
               n++;
               oh = '0; oh[j] = 1'b1;
               checkVal({tag, "_wen"}, bus.wEnbA, 1);
               checkVal({tag, "_benb"}, bus.bEnbA, oh);
               checkVal({tag, "_wdata"}, bus.wDataA, d[j*BYTEW +: BYTEW]);
               checkVal({tag, "_addr"}, bus.addrA, a);
               checkVal({tag, "_done"}, bus.wrDone, (n == k));
               checkVal({tag, "_busy"}, bus.reqReady, 0);
               @(negedge clk);
            end
         end
      end
      checkVal({tag, "_end_wen"}, bus.wEnbA, 0);
      checkVal({tag, "_end_done"}, bus.wrDone, 0);
      checkVal({tag, "_end_ready"}, bus.reqReady, 1);
   endtask

   task automatic doRead(input string tag, input logic [AW-1:0] a, input logic [DATAW-1:0] exp);
      checkVal({tag, "_ready"}, bus.reqReady, 1);
      bus.reqValid = 1'b1; bus.reqWr = 1'b0; bus.reqAddr = a;
      @(negedge clk);
      bus.reqValid = 1'b0;
      checkVal({tag, "_addr"}, bus.addrA, a);
      checkVal({tag, "_wen"}, bus.wEnbA, 0);
      checkVal({tag, "_benb"}, bus.bEnbA, 0);
      checkVal({tag, "_rsp_early"}, bus.rspValid, 0);
      checkVal({tag, "_ready_t1"}, bus.reqReady, 0);
      @(negedge clk);
      checkVal({tag, "_rsp"}, bus.rspValid, 1);
      checkVal({tag, "_data"}, bus.rspData, exp);
      checkVal({tag, "_ready_t2"}, bus.reqReady, 0);
      @(negedge clk);
      checkVal({tag, "_rsp_end"}, bus.rspValid, 0);
      checkVal({tag, "_ready_t3"}, bus.reqReady, 1);
   endtask

   logic             hWr   [6];
   logic [AW-1:0]    hAddr [6];
   logic [NB-1:0]    hMask [6];
   logic [DATAW-1:0] hData [6];
   int               hGap  [6];

   initial begin
      logic [DATAW-1:0] w;
      logic [DATAW-1:0] expRd;
      logic [AW-1:0]    ra;
      logic [NB-1:0]    rm;
      int gap;
      int base0;
      int base1;
      int base2;

      nChecks = 0; nErrors = 0;
      rstn = 1'b0;
      bus.reqValid = 1'b0; bus.reqWr = 1'b0; bus.reqAddr = '0; bus.reqMask = '0; bus.reqData = '0;
      repeat (3) @(negedge clk);
      checkVal("rst_wen", bus.wEnbA, 0);
      checkVal("rst_benb", bus.bEnbA, 0);
      checkVal("rst_addr", bus.addrA, 0);
      checkVal("rst_wdata", bus.wDataA, 0);
      checkVal("rst_done", bus.wrDone, 0);
      checkVal("rst_rsp", bus.rspValid, 0);
      checkVal("rst_busy", bus.busy, 0);
      rstn = 1'b1;
      @(negedge clk);
      checkVal("rel_ready", bus.reqReady, 1);

      // Full mask: bytes 1..10 over 10 cycles, then read back.
      doWrite("full", 10'h005, 10'h3FF, mkWord(1));
      doRead("full_rd", 10'h005, mkWord(1));

      // Sparse mask over a fully written word.
      doWrite("pre", 10'h3FF, 10'h3FF, mkWord(9'h1A0));
      doWrite("sparse", 10'h3FF, 10'b1000000101, mkWord(9'h050));
      w = mkWord(9'h1A0);
      w[0*BYTEW +: BYTEW] = 9'h050;
      w[2*BYTEW +: BYTEW] = 9'h052;
      w[9*BYTEW +: BYTEW] = 9'h059;
      doRead("sparse_rd", 10'h3FF, w);

      // Zero mask: no RAM write, ready stays high.
      base0 = wenCnt;
      doWrite("zero", 10'h005, 10'h000, mkWord(9'h0EE));
      checkVal("zero_nowen", wenCnt - base0, 0);
      doRead("zero_rd", 10'h005, mkWord(1));

      // reqValid held high across alternating requests.
      hWr[0] = 0; hAddr[0] = 10'h005; hMask[0] = '0;            hData[0] = '0;              hGap[0] = 3;
      hWr[1] = 1; hAddr[1] = 10'h010; hMask[1] = 10'b0000010010; hData[1] = mkWord(9'h111); hGap[1] = 3;
      hWr[2] = 0; hAddr[2] = 10'h010; hMask[2] = '0;            hData[2] = '0;              hGap[2] = 3;
      hWr[3] = 1; hAddr[3] = 10'h011; hMask[3] = 10'h000;       hData[3] = mkWord(9'h0AA); hGap[3] = 1;
      hWr[4] = 1; hAddr[4] = 10'h011; hMask[4] = 10'h200;       hData[4] = mkWord(9'h0C0); hGap[4] = 2;
      hWr[5] = 0; hAddr[5] = 10'h011; hMask[5] = '0;            hData[5] = '0;              hGap[5] = 3;
      base0 = wrDoneCnt; base1 = rspCnt; base2 = wenCnt;
      for (int r = 0; r < 6; r++) begin
         bus.reqValid = 1'b1; bus.reqWr = hWr[r]; bus.reqAddr = hAddr[r];
         bus.reqMask = hMask[r]; bus.reqData = hData[r];
         checkVal("held_ready", bus.reqReady, 1);
         if (hWr[r]) refMem[hAddr[r]] = merge(refMem[hAddr[r]], hData[r], hMask[r]);
         else expRd = refMem[hAddr[r]];
         @(negedge clk);
         if (r == 5) bus.reqValid = 1'b0;
         gap = 1;
         while (!bus.reqReady && gap < 20) begin
            if (bus.rspValid) checkVal("held_rdata", bus.rspData, expRd);
            @(negedge clk);
            gap++;
         end
         checkVal("held_gap", gap, hGap[r]);
      end
      bus.reqValid = 1'b0;
      @(negedge clk);
      checkVal("held_wrdone_cnt", wrDoneCnt - base0, 3);
      checkVal("held_rsp_cnt", rspCnt - base1, 3);
      checkVal("held_wen_cnt", wenCnt - base2, 3);
      w = '0;
      w[1*BYTEW +: BYTEW] = 9'h112;
      w[4*BYTEW +: BYTEW] = 9'h115;
      doRead("held_rd10", 10'h010, w);

      // Reset after the 2nd byte of a 5-byte write.
      base0 = wrDoneCnt;
      bus.reqValid = 1'b1; bus.reqWr = 1'b1; bus.reqAddr = 10'h020;
      bus.reqMask = 10'h01F; bus.reqData = mkWord(9'h0C0);
      @(negedge clk);
      bus.reqValid = 1'b0;
      checkVal("rw_b0", bus.bEnbA, 10'h001);
      @(negedge clk);
      checkVal("rw_b1", bus.bEnbA, 10'h002);
      @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      checkVal("rw_wen", bus.wEnbA, 0);
      checkVal("rw_benb", bus.bEnbA, 0);
      checkVal("rw_addr", bus.addrA, 0);
      checkVal("rw_busy", bus.busy, 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkVal("rw_ready", bus.reqReady, 1);
      checkVal("rw_nodone", wrDoneCnt - base0, 0);
      w = '0;
      w[0*BYTEW +: BYTEW] = 9'h0C0;
      w[1*BYTEW +: BYTEW] = 9'h0C1;
      refMem[10'h020] = w;
      doRead("rw_rd", 10'h020, w);

      // Reset during a read: no response.
      base1 = rspCnt;
      bus.reqValid = 1'b1; bus.reqWr = 1'b0; bus.reqAddr = 10'h005;
      @(negedge clk);
      bus.reqValid = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkVal("rr_norsp", rspCnt - base1, 0);
      checkVal("rr_ready", bus.reqReady, 1);

      // Random traffic against the reference word memory.
      for (int n = 0; n < 12; n++) begin
         ra = AW'($urandom_range(0, MEMD - 1));
         rm = NB'($urandom);
         w  = {$urandom, $urandom, $urandom};
         doWrite("rnd_wr", ra, rm, w);
         doRead("rnd_rd", ra, refMem[ra]);
         ra = AW'($urandom_range(0, MEMD - 1));
         doRead("rnd_rd2", ra, refMem[ra]);
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
